// File: rtl/arb8way16.sv
// Round-robin arbiter with burst locking feeding a one-deep registered
// output stage for a shared 16-bit, 8-to-1 word multiplexer.
module arb8way16 #(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  req,
  input  logic [7:0]  lock,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  input  logic [15:0] data3,
  input  logic [15:0] data4,
  input  logic [15:0] data5,
  input  logic [15:0] data6,
  input  logic [15:0] data7,
  output logic [7:0]  gnt,
  output logic [15:0] out,
  output logic [2:0]  out_src,
  output logic        out_valid,
  input  logic        out_ready
);

  localparam logic [3:0] CAP = 4'(MAX_BURST);

  typedef enum logic {IDLE, OWN} state_t;

  state_t      state, state_n;
  logic [2:0]  ptr;
  logic [2:0]  owner, owner_n;
  logic [3:0]  cnt, cnt_n;
  logic [3:0]  cnt_inc;
  logic        load_en;
  logic        hold;
  logic        grant;
  logic [2:0]  winner;
  logic [15:0] mux_word;

  // Handshakes: a requester's word is consumed in the cycle gnt[i] is high;
  // the output word is consumed at an edge where out_valid && out_ready.
  // The stage may reload whenever it is empty or being drained.
  assign load_en = !out_valid || out_ready;

  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] idx;
    rr_pick = p;
    // Walk from the far end so the candidate closest to p wins last.
    for (int k = 7; k >= 0; k--) begin
      idx = p + 3'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign hold    = (state == OWN) && req[owner] && lock[owner] && (cnt < CAP);
  assign winner  = hold ? owner : rr_pick(req, ptr);
  assign grant   = rst_n && load_en && (req != 8'd0);
  assign gnt     = grant ? (8'b1 << winner) : 8'd0;
  assign cnt_inc = cnt + 4'd1;

  always_comb begin
    mux_word = data0;
    case (winner)
      3'd0: mux_word = data0;
      3'd1: mux_word = data1;
      3'd2: mux_word = data2;
      3'd3: mux_word = data3;
      3'd4: mux_word = data4;
      3'd5: mux_word = data5;
      3'd6: mux_word = data6;
      3'd7: mux_word = data7;
      default: mux_word = data0;
    endcase
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    cnt_n   = cnt;
    if (grant) begin
      if (!lock[winner]) begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end else if (state == OWN && winner == owner) begin
        if (cnt_inc == CAP) begin
          state_n = IDLE;
          cnt_n   = 4'd0;
        end else begin
          cnt_n = cnt_inc;
        end
      end else if (MAX_BURST == 1) begin
        state_n = IDLE;
        cnt_n   = 4'd0;
      end else begin
        state_n = OWN;
        owner_n = winner;
        cnt_n   = 4'd1;
      end
    end else if (load_en) begin
      // Nobody to serve: any ownership lapses.
      state_n = IDLE;
      cnt_n   = 4'd0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= 3'd0;
      cnt       <= 4'd0;
      ptr       <= 3'd0;
      out       <= 16'd0;
      out_src   <= 3'd0;
      out_valid <= 1'b0;
    end else begin
      state <= state_n;
      owner <= owner_n;
      cnt   <= cnt_n;
      if (grant) begin
        out       <= mux_word;
        out_src   <= winner;
        out_valid <= 1'b1;
        ptr       <= winner + 3'd1;
      end else if (load_en && out_valid) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb8way16.sv
// Self-checking bench for arb8way16: directed scenarios plus randomized
// traffic compared against a behavioural arbitration model.
module tb_arb8way16;

  localparam int MB = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  req;
  logic [7:0]  lock;
  logic [15:0] data [8];
  logic [7:0]  gnt;
  logic [15:0] out;
  logic [2:0]  out_src;
  logic        out_valid;
  logic        out_ready;

  int vectors = 0;
  int errors  = 0;

  // Reference model state
  int m_ptr, m_owner, m_cnt;
  bit m_owning;
  logic [18:0] exp_q[$];  // {src, word} granted and not yet drained

  arb8way16 #(.MAX_BURST(MB)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .lock(lock),
    .data0(data[0]), .data1(data[1]), .data2(data[2]), .data3(data[3]),
    .data4(data[4]), .data5(data[5]), .data6(data[6]), .data7(data[7]),
    .gnt(gnt), .out(out), .out_src(out_src), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] model_gnt();
    logic [7:0] r;
    int w;
    r = '0;
    if (!rst_n) return r;
    if (!(exp_q.size() == 0 || out_ready) || req == 8'd0) return r;
    if (m_owning && req[m_owner] && lock[m_owner] && m_cnt < MB) begin
      w = m_owner;
    end else begin
      w = -1;
      for (int k = 0; k < 8; k++)
        if (w < 0 && req[(m_ptr + k) % 8]) w = (m_ptr + k) % 8;
    end
    r[w] = 1'b1;
    return r;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_owning = 0;
    exp_q.delete();
  endtask

  // Advance one clock, updating the model with the inputs seen at the edge.
  task automatic step(output logic [7:0] g);
    int w;
    logic rdy, ld, lk;
    logic [15:0] d;
    g = model_gnt();
    rdy = out_ready;
    ld = (exp_q.size() == 0) || rdy;
    w = 0;
    for (int i = 0; i < 8; i++) if (g[i]) w = i;
    d = data[w];
    lk = lock[w];
    @(posedge clk);
    #1;
    if (exp_q.size() != 0 && rdy) void'(exp_q.pop_front());
    if (g != 8'd0) begin
      exp_q.push_back({3'(w), d});
      m_ptr = (w + 1) % 8;
      if (!lk) begin
        m_owning = 0; m_cnt = 0;
      end else if (m_owning && w == m_owner) begin
        m_cnt++;
        if (m_cnt == MB) begin m_owning = 0; m_cnt = 0; end
      end else if (MB == 1) begin
        m_owning = 0; m_cnt = 0;
      end else begin
        m_owning = 1; m_owner = w; m_cnt = 1;
      end
    end else if (ld) begin
      m_owning = 0; m_cnt = 0;
    end
  endtask

  task automatic apply_reset();
    req = '0; lock = '0;
    #2 rst_n = 1'b0;
    #4 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] g;
    req = 8'hFF; lock = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) data[i] = 16'h1000 + 16'(i);
    for (int k = 0; k < 3; k++) step(g);
    #2;
    vectors++;
    if (out_valid !== 1'b1) begin errors++; $display("FAIL pre_reset_valid: got %b expected 1", out_valid); end
    #1 rst_n = 1'b0;
    #1;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    vectors++;
    if (gnt !== 8'h00) begin errors++; $display("FAIL reset_gnt: got %h expected 00", gnt); end
    vectors++;
    if (out !== 16'h0000) begin errors++; $display("FAIL reset_out: got %h expected 0000", out); end
    vectors++;
    if (out_src !== 3'd0) begin errors++; $display("FAIL reset_src: got %0d expected 0", out_src); end
    @(posedge clk);
    #1;
    vectors++;
    if (out_valid !== 1'b0 || gnt !== 8'h00) begin
      errors++; $display("FAIL reset_hold: got valid=%b gnt=%h expected 0/00", out_valid, gnt);
    end
    #1 rst_n = 1'b1;
    model_reset();
    #1;
    vectors++;
    if (gnt !== 8'h01) begin errors++; $display("FAIL post_reset_gnt: got %h expected 01", gnt); end
    step(g);
    #2;
    vectors++;
    if (out_valid !== 1'b1 || out !== 16'h1000 || out_src !== 3'd0) begin
      errors++; $display("FAIL post_reset_out: got %b/%h/%0d expected 1/1000/0", out_valid, out, out_src);
    end
    req = '0;
    step(g);
  endtask

  task automatic test_basic();
    logic [7:0] g;
    apply_reset();
    req = 8'h01; data[0] = 16'hBEEF; out_ready = 1'b1;
    #2;
    vectors++;
    if (gnt !== 8'h01) begin errors++; $display("FAIL basic_gnt: got %h expected 01", gnt); end
    step(g);
    req = '0;
    #2;
    vectors++;
    if (out !== 16'hBEEF || out_src !== 3'd0 || out_valid !== 1'b1) begin
      errors++; $display("FAIL basic_out: got %h/%0d/%b expected BEEF/0/1", out, out_src, out_valid);
    end
    vectors++;
    if (gnt !== 8'h00) begin errors++; $display("FAIL basic_idle_gnt: got %h expected 00", gnt); end
    step(g);
    #2;
    vectors++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_rotation();
    logic [7:0] g, e;
    apply_reset();
    req = 8'hFF; lock = '0; out_ready = 1'b1;
    for (int i = 0; i < 8; i++) data[i] = 16'h1000 + 16'(i);
    for (int k = 0; k < 10; k++) begin
      #2;
      e = 8'h01 << (k % 8);
      vectors++;
      if (gnt !== e) begin errors++; $display("FAIL rot_gnt[%0d]: got %h expected %h", k, gnt, e); end
      if (k > 0) begin
        vectors++;
        if (out !== 16'h1000 + 16'((k - 1) % 8) || out_valid !== 1'b1) begin
          errors++; $display("FAIL rot_out[%0d]: got %h/%b expected %h/1", k, out, out_valid, 16'h1000 + 16'((k - 1) % 8));
        end
      end
      step(g);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] g, e;
    logic [18:0] held;
    held = exp_q[0];
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #2;
      vectors++;
      if (gnt !== 8'h00) begin errors++; $display("FAIL bp_gnt[%0d]: got %h expected 00", k, gnt); end
      vectors++;
      if (out !== held[15:0] || out_src !== held[18:16] || out_valid !== 1'b1) begin
        errors++; $display("FAIL bp_hold[%0d]: got %h/%0d/%b expected %h/%0d/1", k, out, out_src, out_valid, held[15:0], held[18:16]);
      end
      step(g);
    end
    out_ready = 1'b1;
    #2;
    e = model_gnt();
    vectors++;
    if (gnt !== e || gnt === 8'h00) begin errors++; $display("FAIL bp_resume: got %h expected %h", gnt, e); end
    step(g);
    req = '0;
    step(g);
  endtask

  task automatic test_burst_cap();
    logic [7:0] g;
    int seq[10];
    seq = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
    apply_reset();
    req = 8'h06; lock = 8'h02; out_ready = 1'b1;
    data[1] = 16'hA111; data[2] = 16'hB222;
    for (int k = 0; k < 10; k++) begin
      #2;
      vectors++;
      if (gnt !== (8'h01 << seq[k])) begin errors++; $display("FAIL burst_gnt[%0d]: got %h expected %h", k, gnt, 8'h01 << seq[k]); end
      if (k > 0) begin
        vectors++;
        if (out_src !== 3'(seq[k - 1])) begin errors++; $display("FAIL burst_src[%0d]: got %0d expected %0d", k, out_src, seq[k - 1]); end
      end
      step(g);
    end
    #2;
    vectors++;
    if (out_src !== 3'd2 || out !== 16'hB222) begin errors++; $display("FAIL burst_last: got %0d/%h expected 2/B222", out_src, out); end
  endtask

  task automatic test_early_release();
    logic [7:0] g;
    apply_reset();
    req = 8'h18; lock = 8'h08; out_ready = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      vectors++;
      if (gnt !== 8'h08) begin errors++; $display("FAIL rel_own[%0d]: got %h expected 08", k, gnt); end
      step(g);
    end
    lock = 8'h00;
    #2;
    vectors++;
    if (gnt !== 8'h10) begin errors++; $display("FAIL rel_next: got %h expected 10", gnt); end
    step(g);
    #2;
    vectors++;
    if (out_src !== 3'd4) begin errors++; $display("FAIL rel_src: got %0d expected 4", out_src); end
    vectors++;
    if (gnt !== 8'h08) begin errors++; $display("FAIL rel_ptr: got %h expected 08", gnt); end
    step(g);
  endtask

  task automatic test_wrap();
    logic [7:0] g;
    apply_reset();
    req = 8'h40; lock = '0; out_ready = 1'b1;
    data[6] = 16'h6666; data[7] = 16'h7777; data[0] = 16'h0A0A;
    #2;
    vectors++;
    if (gnt !== 8'h40) begin errors++; $display("FAIL wrap_g6: got %h expected 40", gnt); end
    step(g);
    req = 8'h81;
    #2;
    vectors++;
    if (gnt !== 8'h80) begin errors++; $display("FAIL wrap_g7: got %h expected 80", gnt); end
    step(g);
    #2;
    vectors++;
    if (out_src !== 3'd7 || out !== 16'h7777) begin errors++; $display("FAIL wrap_src7: got %0d/%h expected 7/7777", out_src, out); end
    vectors++;
    if (gnt !== 8'h01) begin errors++; $display("FAIL wrap_g0: got %h expected 01", gnt); end
    step(g);
    req = '0;
    #2;
    vectors++;
    if (out_src !== 3'd0 || out !== 16'h0A0A) begin errors++; $display("FAIL wrap_src0: got %0d/%h expected 0/0A0A", out_src, out); end
    step(g);
  endtask

  task automatic test_random();
    logic [7:0] g, e;
    logic [18:0] f;
    apply_reset();
    for (int i = 0; i < 8; i++) data[i] = 16'($urandom);
    req = 8'($urandom); lock = 8'($urandom); out_ready = 1'b1;
    for (int c = 0; c < 600; c++) begin
      #2;
      e = model_gnt();
      vectors++;
      if (gnt !== e) begin errors++; $display("FAIL rnd_gnt[%0d]: got %h expected %h", c, gnt, e); end
      vectors++;
      if (out_valid !== (exp_q.size() != 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b expected %b", c, out_valid, exp_q.size() != 0); end
      if (exp_q.size() != 0) begin
        f = exp_q[0];
        vectors++;
        if (out !== f[15:0] || out_src !== f[18:16]) begin
          errors++; $display("FAIL rnd_out[%0d]: got %h/%0d expected %h/%0d", c, out, out_src, f[15:0], f[18:16]);
        end
      end
      step(g);
      for (int i = 0; i < 8; i++) begin
        if (!req[i] || g[i]) begin
          req[i] = ($urandom_range(0, 3) != 0);
          data[i] = 16'($urandom);
        end
        lock[i] = ($urandom_range(0, 2) != 0);
      end
      out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; lock = '0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) data[i] = '0;
    #12 rst_n = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_basic();
    test_rotation();
    test_backpressure();
    test_burst_cap();
    test_early_release();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
